// File: rtl/div_pkg.sv
// Shared types and sizes for the sequential restoring divider.
package div_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = $clog2(DIV_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } div_state_e;

endpackage

// File: rtl/sub_33_bit.sv
// Combinational a - b done as a + ~b + 1; borrow is the inverted carry out of the top bit.
module sub_33_bit
    import div_pkg::*;
#(
    parameter int W = DIV_W + 1
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    logic [W:0] sum;

    assign sum      = {1'b0, a_i} + {1'b0, ~b_i} + {{W{1'b0}}, 1'b1};
    assign diff_o   = sum[W-1:0];
    assign borrow_o = ~sum[W];

endmodule

// File: rtl/div_32_bit_seq.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN to add the is_signed port and two's-complement operand handling.
module div_32_bit_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef DIV_SIGNED_EN
    input  logic             is_signed,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             nq_q, nq_d;
    logic             nr_q, nr_d;

    logic             sgn_en;
    logic             a_neg, b_neg;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic             last;
    logic             unused_diff_msb;

`ifdef DIV_SIGNED_EN
    assign sgn_en = is_signed;
`else
    assign sgn_en = 1'b0;
`endif

    assign a_neg = sgn_en & dividend[WIDTH-1];
    assign b_neg = sgn_en & divisor[WIDTH-1];

    // Partial remainder shifted left with the next dividend bit entering at the bottom.
    assign r_shift = {r_q, dq_q[WIDTH-1]};

    sub_33_bit #(
        .W (WIDTH + 1)
    ) u_sub (
        .a_i      (r_shift),
        .b_i      ({1'b0, dvs_q}),
        .diff_o   (diff),
        .borrow_o (borrow)
    );

    // Without a borrow the difference is below the divisor, so its top bit is always zero.
    assign unused_diff_msb = diff[WIDTH];
    assign step_rem        = borrow ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0];
    assign step_quo        = {dq_q[WIDTH-2:0], ~borrow};
    assign last            = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        nq_d    = nq_q;
        nr_d    = nr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    r_d   = '0;
                    dq_d  = a_neg ? neg2c(dividend) : dividend;
                    dvs_d = b_neg ? neg2c(divisor) : divisor;
                    nq_d  = a_neg ^ b_neg;
                    nr_d  = a_neg;
                    if (divisor == '0) begin
                        state_d = FINISH;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        dbz_d   = 1'b0;
                    end
                end
            end
            RUN: begin
                r_d   = step_rem;
                dq_d  = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                // Final bit: results land in the output registers as FINISH is entered.
                if (last) begin
                    state_d = FINISH;
                    quot_d  = nq_q ? neg2c(step_quo) : step_quo;
                    rem_d   = nr_q ? neg2c(step_rem) : step_rem;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            dq_q    <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            nq_q    <= nq_d;
            nr_q    <= nr_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FINISH);
    assign div_by_zero = done & dbz_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;

endmodule

// File: tb/tb_div_32_bit_seq.sv
// Directed bench for div_32_bit_seq; signed cases run when DIV_SIGNED_EN is defined.
module tb_div_32_bit_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
`ifdef DIV_SIGNED_EN
    logic         is_signed;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    div_32_bit_seq #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
`ifdef DIV_SIGNED_EN
        .is_signed   (is_signed),
`endif
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input bit drop_start);
        int lat;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1 && drop_start) start = 1'b0;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        vectors++;
        assert (lat == exp_lat) else begin
            miscompares++;
            $error("FAIL %s latency: observed %0d expected %0d", tag, lat, exp_lat);
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                         input int elat);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        wait_done(tag, elat, 1'b1);
        chk({tag, "_quotient"}, quotient, eq);
        chk({tag, "_remainder"}, remainder, er);
        chk1({tag, "_dbz"}, div_by_zero, edbz);
        chk1({tag, "_busy_at_done"}, busy, 1'b1);
        @(negedge clk);
        chk1({tag, "_done_pulse"}, done, 1'b0);
        chk1({tag, "_busy_after"}, busy, 1'b0);
        chk1({tag, "_dbz_after"}, div_by_zero, 1'b0);
        chk({tag, "_quotient_held"}, quotient, eq);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
`ifdef DIV_SIGNED_EN
        is_signed = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_dbz", div_by_zero, 1'b0);
        chk("rst_quotient", quotient, 32'h0);
        chk("rst_remainder", remainder, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("t1_100div7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        do_op("t2_5div0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
        do_op("t3_maxdiv1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
        do_op("t3_10div11", 32'h0000_000A, 32'h0000_000B, 32'd0, 32'd10, 1'b0, 33);

        // start held high through RUN while operands change
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        chk1("t4_busy", busy, 1'b1);
        dividend = 32'd50;
        divisor  = 32'd6;
        wait_done("t4_first", 32, 1'b0);
        chk("t4_first_quotient", quotient, 32'd14);
        chk("t4_first_remainder", remainder, 32'd2);
        @(negedge clk);
        chk1("t4_idle_done", done, 1'b0);
        chk1("t4_idle_busy", busy, 1'b0);
        chk("t4_idle_quotient", quotient, 32'd14);
        wait_done("t4_second", 33, 1'b1);
        chk("t4_second_quotient", quotient, 32'd8);
        chk("t4_second_remainder", remainder, 32'd2);
        @(negedge clk);

        // reset during RUN
        seen     = 1'b0;
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            seen = seen | done;
        end
        rst_n = 1'b0;
        #1;
        chk1("t5_rst_busy", busy, 1'b0);
        chk1("t5_rst_done", done, 1'b0);
        chk("t5_rst_quotient", quotient, 32'h0);
        chk("t5_rst_remainder", remainder, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            seen = seen | done;
        end
        chk1("t5_no_done", seen, 1'b0);
        do_op("t5_9div3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

`ifdef DIV_SIGNED_EN
        is_signed = 1'b1;
        do_op("t6_m7div2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
        do_op("t6_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
        do_op("t6_sdiv0", 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1);
        is_signed = 1'b0;
        do_op("t6_unsigned", 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 33);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
